// File: rtl/apb_slave_mem.sv
// Word-addressed APB slave memory with programmable wait states, address error
// responses and a sticky protocol-violation flag. Answers one bit of psel.
module apb_slave_mem #(
    parameter int SEL_INDEX   = 0,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [2:0]  psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] pr_data,
    output logic        pready,
    output logic        pslverr,
    output logic        prot_err
);
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [2:0] WS_INIT = 3'(WAIT_STATES);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic              wr_q, wr_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              err_q, err_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              prot_q, prot_d;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [DEPTH];

    logic              sel_s;
    logic              bad_s;
    logic [AW-1:0]     idx_s;
    logic              rd_load_s;
    logic              wr_en_s;
    logic              pready_s;
    logic              pslverr_s;
    logic              unused_s;

    // Decode this instance's select and the word index / legality of the address.
    always_comb begin
        sel_s    = psel[SEL_INDEX];
        idx_s    = paddr[2+AW-1:2];
        bad_s    = (paddr[1:0] != 2'b00) || (paddr[31:2+AW] != {(30-AW){1'b0}});
        unused_s = ^psel;
    end

    // Next-state logic; a setup cycle seen in ACCESS is flagged and then re-captured.
    always_comb begin
        state_d   = state_q;
        wr_d      = wr_q;
        idx_d     = idx_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        prot_d    = prot_q;
        rd_load_s = 1'b0;
        wr_en_s   = 1'b0;
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_s && !penable) begin
                    state_d   = ST_ACCESS;
                    wr_d      = pwrite;
                    idx_d     = idx_s;
                    err_d     = bad_s;
                    cnt_d     = WS_INIT;
                    rd_load_s = !pwrite && !bad_s;
                end else if (sel_s && penable) begin
                    prot_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!sel_s) begin
                    prot_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!penable) begin
                    prot_d    = 1'b1;
                    wr_d      = pwrite;
                    idx_d     = idx_s;
                    err_d     = bad_s;
                    cnt_d     = WS_INIT;
                    rd_load_s = !pwrite && !bad_s;
                end else if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    pready_s  = 1'b1;
                    pslverr_s = err_q;
                    wr_en_s   = wr_q && !err_q;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and status registers.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q <= ST_IDLE;
            wr_q    <= 1'b0;
            idx_q   <= {AW{1'b0}};
            err_q   <= 1'b0;
            cnt_q   <= 3'd0;
            prot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            prot_q  <= prot_d;
        end
    end

    // Storage array; writes commit only on the completing edge of a clean write.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0000_0000;
            end
        end else if (wr_en_s) begin
            mem_q[idx_q] <= pwdata;
        end
    end

    // Read data is fetched in the setup cycle and held until the next good read setup.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            rdata_q <= 32'h0000_0000;
        end else if (rd_load_s) begin
            rdata_q <= mem_q[idx_s];
        end
    end

    assign pr_data  = rdata_q;
    assign pready   = pready_s;
    assign pslverr  = pslverr_s;
    assign prot_err = prot_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: two instances share one APB bus (psel[0] with no wait
// states, psel[1] with three), checked against an array-based reference model.
`timescale 1ns/1ps
module tb_apb_slave_mem;
    localparam int DEPTH = 16;
    localparam int WS0   = 0;
    localparam int WS1   = 3;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] pr_data0, pr_data1;
    logic        pready0, pready1, pslverr0, pslverr1, prot_err0, prot_err1;

    int          total = 0;
    int          bad   = 0;

    logic [31:0] mem_m  [2][DEPTH];
    logic [31:0] last_m [2];
    logic        prot_m [2];
    int          lat_m  [2];

    always #5 hclk = ~hclk;

    apb_slave_mem #(.SEL_INDEX(0), .DEPTH(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pr_data(pr_data0), .pready(pready0),
        .pslverr(pslverr0), .prot_err(prot_err0)
    );

    apb_slave_mem #(.SEL_INDEX(1), .DEPTH(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .hclk(hclk), .hresetn(hresetn), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pr_data(pr_data1), .pready(pready1),
        .pslverr(pslverr1), .prot_err(prot_err1)
    );

    function automatic logic rdy_of(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction
    function automatic logic err_of(input int d);
        return (d == 0) ? pslverr0 : pslverr1;
    endfunction
    function automatic logic [31:0] rd_of(input int d);
        return (d == 0) ? pr_data0 : pr_data1;
    endfunction
    function automatic logic prot_of(input int d);
        return (d == 0) ? prot_err0 : prot_err1;
    endfunction

    // Reference model: byte address is legal when word aligned and inside DEPTH words.
    function automatic logic addr_bad(input logic [31:0] a);
        return ((a % 32'd4) != 32'd0) || (a >= 32'(DEPTH * 4));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) mem_m[d][i] = 32'h0;
            last_m[d] = 32'h0;
            prot_m[d] = 1'b0;
        end
        lat_m[0] = 1 + WS0;
        lat_m[1] = 1 + WS1;
    endtask

    task automatic model_xfer(input int d, input logic wr, input logic [31:0] a, input logic [31:0] data);
        if (!addr_bad(a)) begin
            if (wr) mem_m[d][a / 32'd4] = data;
            else    last_m[d] = mem_m[d][a / 32'd4];
        end
    endtask

    task automatic bus_idle();
        @(negedge hclk);
        psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
    endtask

    // Drives one setup + access sequence; reports the access cycle that saw pready.
    task automatic do_xfer(input int d, input logic [2:0] ps, input logic wr, input logic [31:0] a,
                           input logic [31:0] data, output int rdy_cyc, output logic err,
                           output logic [31:0] rdata, output logic other_rdy);
        rdy_cyc = -1; err = 1'b0; other_rdy = 1'b0;
        @(negedge hclk);
        psel = ps; penable = 1'b0; pwrite = wr; paddr = a; pwdata = data;
        #1 other_rdy = rdy_of(1 - d) | rdy_of(d);
        for (int n = 1; n <= 12; n++) begin
            @(negedge hclk);
            penable = 1'b1;
            #1;
            other_rdy = other_rdy | rdy_of(1 - d);
            if (rdy_of(d)) begin
                rdy_cyc = n;
                err = err_of(d);
                break;
            end
        end
        rdata = rd_of(d);
    endtask

    task automatic test_reset();
        int rc; logic e, o; logic [31:0] rd;
        hresetn = 1'b0; psel = 3'b000; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        model_reset();
        @(negedge hclk);
        #1;
        total++;
        if ({pr_data0, pready0, pslverr0, prot_err0} !== 35'h0) begin
            bad++; $display("FAIL reset_dut0: got %h want 0", {pr_data0, pready0, pslverr0, prot_err0});
        end
        total++;
        if ({pr_data1, pready1, pslverr1, prot_err1} !== 35'h0) begin
            bad++; $display("FAIL reset_dut1: got %h want 0", {pr_data1, pready1, pslverr1, prot_err1});
        end
        @(negedge hclk);
        hresetn = 1'b1;
        do_xfer(0, 3'b001, 1'b0, 32'h0, 32'h0, rc, e, rd, o);
        model_xfer(0, 1'b0, 32'h0, 32'h0);
        total++;
        if (rc !== 1 || e !== 1'b0 || rd !== 32'h0) begin
            bad++; $display("FAIL reset_read: got lat=%0d err=%b data=%h want lat=1 err=0 data=0", rc, e, rd);
        end
        bus_idle();
    endtask

    task automatic test_write_read();
        int rc; logic e, o; logic [31:0] rd;
        do_xfer(0, 3'b001, 1'b1, 32'h0C, 32'hDEAD_BEEF, rc, e, rd, o);
        model_xfer(0, 1'b1, 32'h0C, 32'hDEAD_BEEF);
        total++;
        if (rc !== 1 || e !== 1'b0) begin
            bad++; $display("FAIL wr_resp: got lat=%0d err=%b want lat=1 err=0", rc, e);
        end
        bus_idle();
        do_xfer(0, 3'b001, 1'b0, 32'h0C, 32'h0, rc, e, rd, o);
        model_xfer(0, 1'b0, 32'h0C, 32'h0);
        total++;
        if (rd !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL rd_0c: got %h want %h", rd, 32'hDEAD_BEEF);
        end
        bus_idle();
        do_xfer(0, 3'b001, 1'b0, 32'h08, 32'h0, rc, e, rd, o);
        model_xfer(0, 1'b0, 32'h08, 32'h0);
        total++;
        if (rd !== 32'h0 || rc !== 1) begin
            bad++; $display("FAIL rd_08: got data=%h lat=%0d want data=0 lat=1", rd, rc);
        end
        bus_idle();
    endtask

    task automatic test_wait_states();
        int rc; logic e, o; logic [31:0] rd;
        do_xfer(1, 3'b010, 1'b1, 32'h3C, 32'h1234_5678, rc, e, rd, o);
        model_xfer(1, 1'b1, 32'h3C, 32'h1234_5678);
        total++;
        if (rc !== 4 || e !== 1'b0) begin
            bad++; $display("FAIL ws_write_lat: got lat=%0d err=%b want lat=4 err=0", rc, e);
        end
        bus_idle();
        do_xfer(1, 3'b010, 1'b0, 32'h3C, 32'h0, rc, e, rd, o);
        model_xfer(1, 1'b0, 32'h3C, 32'h0);
        total++;
        if (rd !== 32'h1234_5678 || rc !== 4) begin
            bad++; $display("FAIL ws_readback: got data=%h lat=%0d want data=%h lat=4", rd, rc, 32'h1234_5678);
        end
        bus_idle();
    endtask

    task automatic test_errors();
        int rc; logic e, o; logic [31:0] rd;
        do_xfer(0, 3'b001, 1'b1, 32'h02, 32'h5555_5555, rc, e, rd, o);
        total++;
        if (rc !== 1 || e !== 1'b1) begin
            bad++; $display("FAIL err_misalign: got lat=%0d err=%b want lat=1 err=1", rc, e);
        end
        bus_idle();
        do_xfer(0, 3'b001, 1'b1, 32'h40, 32'h5555_5555, rc, e, rd, o);
        total++;
        if (rc !== 1 || e !== 1'b1) begin
            bad++; $display("FAIL err_range: got lat=%0d err=%b want lat=1 err=1", rc, e);
        end
        bus_idle();
        do_xfer(0, 3'b001, 1'b0, 32'h00, 32'h0, rc, e, rd, o);
        model_xfer(0, 1'b0, 32'h00, 32'h0);
        total++;
        if (rd !== mem_m[0][0] || e !== 1'b0) begin
            bad++; $display("FAIL err_after_rd: got data=%h err=%b want data=%h err=0", rd, e, mem_m[0][0]);
        end
        bus_idle();
        do_xfer(1, 3'b010, 1'b0, 32'h8000_0004, 32'h0, rc, e, rd, o);
        total++;
        if (rc !== 4 || e !== 1'b1 || rd !== last_m[1]) begin
            bad++; $display("FAIL err_rd_hold: got lat=%0d err=%b data=%h want lat=4 err=1 data=%h", rc, e, rd, last_m[1]);
        end
        bus_idle();
    endtask

    task automatic test_select();
        int rc; logic e, o; logic [31:0] rd;
        do_xfer(1, 3'b010, 1'b1, 32'h00, 32'hCAFE_0001, rc, e, rd, o);
        model_xfer(1, 1'b1, 32'h00, 32'hCAFE_0001);
        total++;
        if (o !== 1'b0 || rc !== 4) begin
            bad++; $display("FAIL sel_other: got dut0_ready=%b lat=%0d want dut0_ready=0 lat=4", o, rc);
        end
        bus_idle();
        do_xfer(0, 3'b100, 1'b1, 32'h00, 32'hCAFE_0002, rc, e, rd, o);
        total++;
        if (rc !== -1 || o !== 1'b0) begin
            bad++; $display("FAIL sel_none: got lat=%0d other=%b want no pready", rc, o);
        end
        bus_idle();
        do_xfer(0, 3'b001, 1'b0, 32'h00, 32'h0, rc, e, rd, o);
        model_xfer(0, 1'b0, 32'h00, 32'h0);
        total++;
        if (rd !== mem_m[0][0] || prot_err0 !== prot_m[0]) begin
            bad++; $display("FAIL sel_mem: got data=%h prot=%b want data=%h prot=%b", rd, prot_err0, mem_m[0][0], prot_m[0]);
        end
        bus_idle();
    endtask

    task automatic test_protocol();
        int rc; logic e, o; logic [31:0] rd;
        @(negedge hclk);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04; pwdata = 32'hBAD0_0004;
        @(negedge hclk);
        psel = 3'b000; penable = 1'b1;
        prot_m[0] = 1'b1;
        bus_idle();
        #1;
        total++;
        if (prot_err0 !== 1'b1 || prot_err1 !== 1'b0) begin
            bad++; $display("FAIL abort_flag: got prot0=%b prot1=%b want 1 0", prot_err0, prot_err1);
        end
        do_xfer(0, 3'b001, 1'b0, 32'h04, 32'h0, rc, e, rd, o);
        model_xfer(0, 1'b0, 32'h04, 32'h0);
        total++;
        if (rd !== mem_m[0][1]) begin
            bad++; $display("FAIL abort_mem: got %h want %h", rd, mem_m[0][1]);
        end
        bus_idle();
        @(negedge hclk);
        psel = 3'b010; penable = 1'b1; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h7777_7777;
        #1;
        total++;
        if (pready1 !== 1'b0) begin
            bad++; $display("FAIL nosetup_ready: got %b want 0", pready1);
        end
        prot_m[1] = 1'b1;
        bus_idle();
        #1;
        total++;
        if (prot_err1 !== 1'b1) begin
            bad++; $display("FAIL nosetup_flag: got %b want 1", prot_err1);
        end
        @(negedge hclk);
        psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08; pwdata = 32'h1111_2222;
        @(negedge hclk);
        pwrite = 1'b0; paddr = 32'h0C;
        model_xfer(0, 1'b0, 32'h0C, 32'h0);
        @(negedge hclk);
        penable = 1'b1;
        #1;
        total++;
        if (pready0 !== 1'b1 || pslverr0 !== 1'b0 || pr_data0 !== last_m[0]) begin
            bad++; $display("FAIL resetup: got rdy=%b err=%b data=%h want rdy=1 err=0 data=%h", pready0, pslverr0, pr_data0, last_m[0]);
        end
        bus_idle();
        do_xfer(0, 3'b001, 1'b0, 32'h08, 32'h0, rc, e, rd, o);
        model_xfer(0, 1'b0, 32'h08, 32'h0);
        total++;
        if (rd !== mem_m[0][2]) begin
            bad++; $display("FAIL resetup_mem: got %h want %h", rd, mem_m[0][2]);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        int rc; logic e, o; logic [31:0] rd;
        for (int d = 0; d < 2; d++) begin
            do_xfer(d, (d == 0) ? 3'b001 : 3'b010, 1'b1, 32'h10, 32'hA5A5_A5A5, rc, e, rd, o);
            model_xfer(d, 1'b1, 32'h10, 32'hA5A5_A5A5);
            do_xfer(d, (d == 0) ? 3'b001 : 3'b010, 1'b0, 32'h10, 32'h0, rc, e, rd, o);
            model_xfer(d, 1'b0, 32'h10, 32'h0);
            total++;
            if (rd !== 32'hA5A5_A5A5 || rc !== lat_m[d]) begin
                bad++; $display("FAIL b2b_raw%0d: got data=%h lat=%0d want data=%h lat=%0d", d, rd, rc, 32'hA5A5_A5A5, lat_m[d]);
            end
            bus_idle();
        end
    endtask

    task automatic test_random();
        int rc, d; logic e, o, wr, eb; logic [31:0] rd, a, data;
        for (int k = 0; k < 40; k++) begin
            d    = $urandom_range(0, 1);
            wr   = 1'($urandom_range(0, 1));
            data = $urandom;
            if ($urandom_range(0, 5) == 0) a = $urandom;
            else a = 32'($urandom_range(0, DEPTH - 1)) * 32'd4;
            eb = addr_bad(a);
            do_xfer(d, (d == 0) ? 3'b001 : 3'b010, wr, a, data, rc, e, rd, o);
            model_xfer(d, wr, a, data);
            total++;
            if (rc !== lat_m[d] || e !== eb || rd !== last_m[d] || o !== 1'b0 || prot_of(d) !== prot_m[d]) begin
                bad++;
                $display("FAIL rand%0d: dut%0d a=%h wr=%b got lat=%0d err=%b data=%h oth=%b prot=%b want lat=%0d err=%b data=%h oth=0 prot=%b",
                         k, d, a, wr, rc, e, rd, o, prot_of(d), lat_m[d], eb, last_m[d], prot_m[d]);
            end
            if ($urandom_range(0, 1) == 0) bus_idle();
        end
        bus_idle();
    endtask

    task automatic test_reset_mid();
        int rc; logic e, o; logic [31:0] rd;
        @(negedge hclk);
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'hFEED_F00D;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        #2 hresetn = 1'b0;
        #1;
        total++;
        if ({pr_data1, pready1, pslverr1, prot_err1, prot_err0} !== 36'h0) begin
            bad++; $display("FAIL midreset_out: got %h want 0", {pr_data1, pready1, pslverr1, prot_err1, prot_err0});
        end
        @(negedge hclk);
        psel = 3'b000; penable = 1'b0;
        hresetn = 1'b1;
        model_reset();
        do_xfer(1, 3'b010, 1'b0, 32'h20, 32'h0, rc, e, rd, o);
        model_xfer(1, 1'b0, 32'h20, 32'h0);
        total++;
        if (rd !== 32'h0 || rc !== 4) begin
            bad++; $display("FAIL midreset_mem: got data=%h lat=%0d want data=0 lat=4", rd, rc);
        end
        bus_idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_errors();
        test_select();
        test_protocol();
        test_back_to_back();
        test_random();
        #1;
        total++;
        if (prot_err0 !== 1'b1 || prot_err1 !== 1'b1) begin
            bad++; $display("FAIL prot_sticky: got %b %b want 1 1", prot_err0, prot_err1);
        end
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

Word-addressed APB slave memory that sits directly downstream of the AHB-to-APB bridge. It consumes the bridge's `psel`/`penable`/`pwrite`/`paddr`/`pwdata` outputs and returns `pr_data`, `pready` and `pslverr`. It gives the bridge a real, stateful peripheral with programmable wait states and error responses, replacing the pass-through APB interface for end-to-end read-after-write checks. One instance answers one `psel` bit.

## Interface
Parameters:
- `SEL_INDEX`, 0: which bit of `psel[2:0]` selects this instance (0..2).
- `DEPTH`, 16: number of 32-bit words; power of two, 2..256.
- `WAIT_STATES`, 0: extra access cycles with `pready`=0 before completion (0..7).

Ports:
- `hclk` in, 1: single clock; all state changes on the rising edge.
- `hresetn` in, 1: reset; asynchronous, active-low.
- `psel` in, 3: APB slave selects from the bridge; only `psel[SEL_INDEX]` is used.
- `penable` in, 1: APB access-phase strobe.
- `pwrite` in, 1: 1 = write, 0 = read; sampled in the setup cycle.
- `paddr` in, 32: byte address; sampled in the setup cycle.
- `pwdata` in, 32: write data; sampled in the completing cycle.
- `pr_data` out, 32: read data, registered.
- `pready` out, 1: transfer completes this cycle.
- `pslverr` out, 1: error response; valid only when `pready`=1.
- `prot_err` out, 1: sticky protocol-violation flag.

## Operation
- `sel` = `psel[SEL_INDEX]`.
- `idx` = `paddr[2+AW-1:2]`, where AW = log2(DEPTH).
- `bad` = (`paddr[1:0]` != 0) or (`paddr[31:2+AW]` != 0).
- FSM states: IDLE and ACCESS.
- IDLE: on `sel`=1 and `penable`=0 (setup cycle), go to ACCESS and capture:
  - `wr_q` <= `pwrite`, `idx_q` <= idx, `err_q` <= bad, `cnt` <= WAIT_STATES;
  - if `pwrite`=0 and `bad`=0, also `pr_data` <= mem[idx].
- IDLE with `penable`=1 and `sel`=1 (access without setup): set `prot_err`, stay in IDLE, no memory effect, `pready` stays 0.
- ACCESS with `sel`=1, `penable`=1:
  - if `cnt` != 0: `cnt` decrements, `pready`=0;
  - if `cnt`=0: `pready`=1, `pslverr`=`err_q`, next state IDLE.
- Write commit: on the completing edge, if `wr_q`=1 and `err_q`=0, then mem[`idx_q`] <= `pwdata`.
- Error transfers: errored writes leave memory unchanged; errored reads leave `pr_data` unchanged.
- ACCESS with `sel`=0 (abort): set `prot_err`, return to IDLE, no write.
- ACCESS with `sel`=1, `penable`=0: treated as a fresh setup. Set `prot_err`, then re-capture as from IDLE.
- `pready` and `pslverr` are combinational from state, `cnt`, `err_q` and `penable`. They are 0 whenever the block is not in ACCESS.
- Transfers with `psel[SEL_INDEX]`=0 are ignored entirely.

## Timing
- Reset (asynchronous assert, synchronous-release use):
  - all mem words = 0, `pr_data` = 0, state IDLE, `cnt` = 0;
  - `pready` = 0, `pslverr` = 0, `prot_err` = 0.
- Reset mid-transfer aborts the transfer; no partial write occurs.
- Latency: setup cycle T0, then the access phase completes at T(1+WAIT_STATES).
  - WAIT_STATES=0: `pready`=1 in T1.
  - WAIT_STATES=2: `pready`=0 in T1 and T2, `pready`=1 in T3.
- Read data is valid from T1 and held until the next accepted read setup.
- Back-to-back: a new setup in the cycle right after completion is accepted. Sustained throughput is one transfer per 2+WAIT_STATES cycles.
- Read-after-write to the same address across consecutive transfers returns the new data: the write commits at the completing edge, and the read samples one cycle later.
- `prot_err` clears only on reset.

## Test plan
- Reset then idle: `hresetn` low for one cycle → all outputs 0; a read of addr 0x0 returns 0x0000_0000 with `pready`=1 in T1 and `pslverr`=0.
- Write/read, WAIT_STATES=0: write 0xDEAD_BEEF to 0x0C, then read 0x0C → `pr_data`=0xDEAD_BEEF. Address 0x08 still reads 0.
- Wait states, WAIT_STATES=3: write 0x1234_5678 to 0x3C → `pready` is 0 for 3 access cycles and 1 in the 4th. A readback of 0x3C matches.
- Errors:
  - write 0x5555_5555 to 0x02 → `pready`=1, `pslverr`=1;
  - write to 0x40 (DEPTH=16) → `pslverr`=1;
  - read 0x00 afterwards returns its prior value, with `pslverr`=0.
- Select and protocol violations:
  - transfer with only `psel[1]` set (SEL_INDEX=0) → no `pready`, memory unchanged;
  - drop `psel` mid-ACCESS of a write to 0x04 → `prot_err`=1 and 0x04 unchanged;
  - `prot_err` stays 1 until reset.
- Bridge end-to-end: drive the AHB master single write of 0xA5A5_A5A5 to 0x0000_0010, then a single read of the same address → the bridge returns 0xA5A5_A5A5 on `hr_data`.
